two_digit_seg7_display: RTL

//  Downstream consumer of the 0-99 two-digit counter. Samples its 8-bit binary count,

---
 rtl/two_digit_seg7_display.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/two_digit_seg7_display.sv
// Two-digit multiplexed 7-segment display fed by an 8-bit binary count.
// Optional macro LEADING_ZERO_BLANK_EN darkens the tens digit when it is a leading zero.
`timescale 1ns/1ps

module two_digit_seg7_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       ovf,
  output logic       conv_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD
  } state_t;

  state_t           state;
  logic [7:0]       shreg;
  logic [11:0]      bcd;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] scan_cnt;
  logic             sel;

  logic [7:0]       bcd_adj;
  logic             load_now;
  logic             hundreds_set;
  logic             ovf_next;
  logic [3:0]       tens_next;
  logic [3:0]       ones_next;
  logic             scan_wrap;
  logic             sel_next;
  logic [3:0]       digit_next;
  logic [7:0]       an_next;
  logic [6:0]       seg_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Add-3 correction for tens/ones; hundreds never reaches 5 for an 8-bit input.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? bcd[4*gi +: 4] + 4'd3
                                                          : bcd[4*gi +: 4];
    end
  endgenerate

  assign load_now     = (state == S_LOAD);
  assign hundreds_set = (bcd[11:8] != 4'd0);
  assign ovf_next     = load_now ? hundreds_set : ovf;
  assign tens_next    = (load_now && !hundreds_set) ? bcd[7:4] : bcd_tens;
  assign ones_next    = (load_now && !hundreds_set) ? bcd[3:0] : bcd_ones;

  assign scan_wrap    = (scan_cnt == CNT_LAST);
  assign sel_next     = scan_wrap ? ~sel : sel;

  // Display is driven from next-state digit/select so a wrap coinciding with a load shows the new value.
  always_comb begin
    digit_next = sel_next ? tens_next : ones_next;
    an_next    = sel_next ? 8'b1111_1101 : 8'b1111_1110;
    seg_next   = ovf_next ? 7'b0111111 : decode(digit_next);
`ifdef LEADING_ZERO_BLANK_EN
    if (sel_next && !ovf_next && (tens_next == 4'd0)) begin
      an_next  = 8'hFF;
      seg_next = 7'h7F;
    end
`endif
  end

  assign dp = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      bcd_tens  <= '0;
      bcd_ones  <= '0;
      ovf       <= 1'b0;
      conv_done <= 1'b0;
      scan_cnt  <= '0;
      sel       <= 1'b0;
      an        <= 8'hFF;
      seg       <= 7'h7F;
    end else begin
      conv_done <= 1'b0;
      case (state)
        S_IDLE: begin
          shreg   <= value;
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= S_CONV;
        end
        S_CONV: begin
          bcd     <= {bcd[10:8], bcd_adj, shreg[7]};
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          ovf       <= ovf_next;
          bcd_tens  <= tens_next;
          bcd_ones  <= ones_next;
          conv_done <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      sel      <= sel_next;
      an       <= an_next;
      seg      <= seg_next;
    end
  end

endmodule
